mem_stage_ctrl: RTL

MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

---
 rtl/mem_stage_ctrl.sv | 119 +++++++++++
 1 files changed

// File: rtl/mem_stage_ctrl.sv
// M-stage data-memory handshake controller: IDLE -> ACCESS -> DONE per access.
// Define MEM_TIMEOUT_EN to bound the MemAck wait to TIMEOUT_CYCLES cycles.
module mem_stage_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        MemtoRegM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  output logic        MemReq,
  output logic        MemWe,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWData,
  input  logic        MemAck,
  input  logic [31:0] MemRData,
  output logic        StallM,
  output logic [31:0] ReadDataM,
  output logic        MemErrM
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        access, misal, is_load;
  logic        in_idle, in_acc;
  logic        to_hit;

  assign access  = MemtoRegM | MemWriteM;
  assign misal   = |ALUOutM[1:0];
  assign is_load = MemtoRegM & ~MemWriteM;
  assign in_idle = (state_q == IDLE);
  assign in_acc  = (state_q == ACCESS);

`ifdef MEM_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] cnt_q, cnt_d;

  assign to_hit = in_acc & (cnt_q == TO_LAST);

  // Zero while idle so every ACCESS entry starts a fresh count.
  always_comb begin
    cnt_d = cnt_q;
    if (in_idle)
      cnt_d = '0;
    else if (in_acc && !MemAck)
      cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  logic unused_cfg;

  assign to_hit     = 1'b0;
  assign unused_cfg = (TIMEOUT_CYCLES != 0);
`endif

  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (access) begin
          if (misal) begin
            state_d = DONE;
            err_d   = 1'b1;
          end else begin
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (MemAck) begin
          state_d = DONE;
          if (is_load) rdata_d = MemRData;
        end else if (to_hit) begin
          state_d = DONE;
          err_d   = 1'b1;
          if (is_load) rdata_d = 32'hDEADBEEF;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign MemReq    = in_acc;
  assign MemWe     = in_acc & MemWriteM;
  assign MemAddr   = in_acc ? {ALUOutM[31:2], 2'b00} : '0;
  assign MemWData  = in_acc ? WriteDataM : '0;
  assign StallM    = (in_idle & access) | in_acc;
  assign ReadDataM = rdata_q;
  assign MemErrM   = err_q;

endmodule
